// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin share of one I2C command controller between two config requesters.
// Optional: define I2C_ARB_TIMEOUT_EN to add a busy watchdog that completes a hung transfer with err.
module i2c_arbiter #(
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int CNT_W          = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [6:0] r0_address,
  input  logic [6:0] r1_address,
  input  logic [7:0] r0_data_0,
  input  logic [7:0] r1_data_0,
  input  logic [7:0] r0_data_1,
  input  logic [7:0] r1_data_1,
  output logic       ack0,
  output logic       ack1,
  output logic       err0,
  output logic       err1,
  output logic [1:0] grant,
  output logic       i2c_start,
  output logic [6:0] cmd_address,
  output logic [7:0] data_0,
  output logic [7:0] data_1,
  input  logic       i2c_busy
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, DONE} state_t;

  state_t r_state;
  logic   r_last;
  logic   w_pick1;
  logic   w_done_ok;
  logic   w_expire;
  logic   w_finish;

  // req1 wins when alone, or on a tie when req0 was served last
  assign w_pick1   = req1 & (~req0 | ~r_last);
  assign w_done_ok = (r_state == WAIT_DONE) & ~i2c_busy;
  assign w_finish  = w_done_ok | w_expire;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  // A genuine busy edge in the same cycle takes priority over the watchdog
  assign w_expire = (((r_state == WAIT_BUSY) & ~i2c_busy) | ((r_state == WAIT_DONE) & i2c_busy)) &
                    (r_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      err0  <= 1'b0;
      err1  <= 1'b0;
    end else begin
      err0 <= w_expire & grant[0];
      err1 <= w_expire & grant[1];
      if (r_state == IDLE)
        r_cnt <= '0;
      else if (r_state == WAIT_BUSY || r_state == WAIT_DONE)
        r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_expire = 1'b0;
  assign err0     = 1'b0;
  assign err1     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      grant       <= 2'b00;
      i2c_start   <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      cmd_address <= '0;
      data_0      <= '0;
      data_1      <= '0;
    end else begin
      i2c_start <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      case (r_state)
        IDLE: begin
          if ((req0 | req1) && !i2c_busy) begin
            r_last      <= w_pick1;
            grant       <= w_pick1 ? 2'b10 : 2'b01;
            cmd_address <= w_pick1 ? r1_address : r0_address;
            data_0      <= w_pick1 ? r1_data_0 : r0_data_0;
            data_1      <= w_pick1 ? r1_data_1 : r0_data_1;
            i2c_start   <= 1'b1;
            r_state     <= LAUNCH;
          end
        end
        LAUNCH: r_state <= WAIT_BUSY;
        WAIT_BUSY, WAIT_DONE: begin
          if (w_finish) begin
            ack0    <= grant[0];
            ack1    <= grant[1];
            r_state <= DONE;
          end else if (r_state == WAIT_BUSY && i2c_busy) begin
            r_state <= WAIT_DONE;
          end
        end
        DONE: begin
          grant   <= 2'b00;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Follows the build: I2C_ARB_TIMEOUT_EN selects the watchdog scenario.
module tb_i2c_arbiter;
  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [6:0] r0_address = '0, r1_address = '0;
  logic [7:0] r0_data_0 = '0, r1_data_0 = '0, r0_data_1 = '0, r1_data_1 = '0;
  logic       ack0, ack1, err0, err1, i2c_start;
  logic [1:0] grant;
  logic [6:0] cmd_address;
  logic [7:0] data_0, data_1;
  logic       i2c_busy;

  logic ctl_manual = 1'b1, man_busy = 1'b0, auto_busy = 1'b0;
  assign i2c_busy = ctl_manual ? man_busy : auto_busy;

  i2c_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_W(12)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .r0_address(r0_address), .r1_address(r1_address),
    .r0_data_0(r0_data_0), .r1_data_0(r1_data_0),
    .r0_data_1(r0_data_1), .r1_data_1(r1_data_1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .grant(grant), .i2c_start(i2c_start), .cmd_address(cmd_address),
    .data_0(data_0), .data_1(data_1), .i2c_busy(i2c_busy));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int         m_owner = -1;   // -1: nobody holds the controller
  bit         m_last = 1'b1;
  bit         m_launch = 1'b0, m_seen = 1'b0, m_done = 1'b0, m_fin, m_tmo, m_rise;
  int         m_wait = 0;
  logic [1:0] e_grant = '0, e_ack = '0, e_err = '0;
  logic       e_start = 1'b0;
  logic [6:0] e_addr = '0;
  logic [7:0] e_d0 = '0, e_d1 = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = -1; m_last = 1'b1; m_launch = 0; m_seen = 0; m_done = 0; m_wait = 0;
      e_grant = '0; e_ack = '0; e_err = '0; e_start = 0; e_addr = '0; e_d0 = '0; e_d1 = '0;
    end else begin
      e_start = 0; e_ack = '0; e_err = '0;
      if (m_done) begin
        m_done = 0; m_owner = -1; e_grant = '0;
      end else if (m_owner < 0) begin
        if ((req0 || req1) && !i2c_busy) begin
          m_owner = (req0 && req1) ? (m_last ? 0 : 1) : (req1 ? 1 : 0);
          m_last  = (m_owner == 1);
          e_grant = 2'(1 << m_owner);
          {e_addr, e_d0, e_d1} = (m_owner == 1) ? {r1_address, r1_data_0, r1_data_1}
                                                : {r0_address, r0_data_0, r0_data_1};
          e_start = 1; m_launch = 1; m_seen = 0; m_wait = 0;
        end
      end else if (m_launch) begin
        m_launch = 0;
      end else begin
        m_wait++;
        m_fin  = m_seen && !i2c_busy;
        m_rise = !m_seen && i2c_busy;
        if (m_rise) m_seen = 1;
        m_tmo = 0;
`ifdef I2C_ARB_TIMEOUT_EN
        m_tmo = !m_fin && !m_rise && (m_wait >= TMO);
`endif
        if (m_fin || m_tmo) begin
          m_done = 1; e_ack[m_owner] = 1'b1; e_err[m_owner] = m_tmo;
        end
      end
    end
  end

  bit chk_on = 1'b0;
  always @(negedge clk) begin
    if (chk_on) begin
      check("grant", 32'(grant), 32'(e_grant));
      check("i2c_start", 32'(i2c_start), 32'(e_start));
      check("ack0", 32'(ack0), 32'(e_ack[0]));
      check("ack1", 32'(ack1), 32'(e_ack[1]));
      check("cmd_address", 32'(cmd_address), 32'(e_addr));
      check("data_0", 32'(data_0), 32'(e_d0));
      check("data_1", 32'(data_1), 32'(e_d1));
`ifdef I2C_ARB_TIMEOUT_EN
      if (e_ack[0]) check("err0", 32'(err0), 32'(e_err[0]));
      if (e_ack[1]) check("err1", 32'(err1), 32'(e_err[1]));
`else
      check("err0_const", 32'(err0), 0);
      check("err1_const", 32'(err1), 0);
`endif
    end
  end

  // ---------------- controller stand-in ----------------
  bit  ctl_rand = 1'b0;
  int  ctl_dly = 2, ctl_hold = 30;
  int  cph = 0, cdly = 0, chold = 0, ctail = 0;
  time fall_t = 0;

  always @(negedge clk) begin
    if (!rst || ctl_manual) begin
      cph = 0; auto_busy = 1'b0;
    end else begin
      case (cph)
        0: if (i2c_start) begin
          cdly  = ctl_rand ? int'($urandom_range(0, 4)) : ctl_dly;
          chold = ctl_rand ? int'($urandom_range(0, 20)) : ctl_hold;
          ctail = (ctl_rand && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
          cph = 1;
        end
        1: if (cdly == 0) begin auto_busy = 1'b1; cph = 2; end else cdly--;
        2: if (chold == 0) begin
          auto_busy = 1'b0; fall_t = $time; cph = (ctail > 0) ? 3 : 0;
        end else chold--;
        // trailing busy after completion models a controller still winding down
        default: if (ctail == 0) begin auto_busy = 1'b0; cph = 0; end
                 else begin auto_busy = 1'b1; ctail--; end
      endcase
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_ack(input int idx, input int budget, input string nm);
    int n = 0;
    while (((idx == 0) ? ack0 : ack1) !== 1'b1 && n < budget) begin
      @(negedge clk); n++;
    end
    check({nm, "_ack_seen"}, 32'((idx == 0) ? ack0 : ack1), 1);
    if (idx == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk); #2 rst = 1'b0; #1;
    check({nm, "_grant"}, 32'(grant), 0);
    check({nm, "_start"}, 32'(i2c_start), 0);
    check({nm, "_ack"}, 32'({ack1, ack0}), 0);
    @(negedge clk); #2 rst = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got stuck, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n, cnt;
    logic [6:0] sv_addr;

    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    check("reset_grant", 32'(grant), 0);
    check("reset_outs", 32'({cmd_address, data_0, data_1}), 0);
    check("reset_pulses", 32'({ack0, ack1, err0, err1, i2c_start}), 0);
    #2 rst = 1'b1;

    // single request
    ctl_manual = 1'b0; ctl_rand = 1'b0; ctl_dly = 2; ctl_hold = 30;
    @(negedge clk);
    req0 = 1'b1; r0_address = 7'h39; r0_data_0 = 8'h41; r0_data_1 = 8'h10;
    @(negedge clk);
    check("t1_start", 32'(i2c_start), 1);
    check("t1_addr", 32'(cmd_address), 'h39);
    check("t1_d0", 32'(data_0), 'h41);
    check("t1_d1", 32'(data_1), 'h10);
    check("t1_grant", 32'(grant), 'b01);
    wait_ack(0, 200, "t1");
    check("t1_ack_latency", 32'($time - fall_t), 10);
    check("t1_err0", 32'(err0), 0);
    @(negedge clk);
    check("t1_ack_width", 32'(ack0), 0);

    // tie after reset, then re-raise for a second round
    do_reset("t2_rst");
    @(negedge clk);
    req0 = 1'b1; r0_address = 7'h11; r0_data_0 = 8'h01; r0_data_1 = 8'h02;
    req1 = 1'b1; r1_address = 7'h22; r1_data_0 = 8'h03; r1_data_1 = 8'h04;
    @(negedge clk);
    check("t2_first", 32'(grant), 'b01);
    wait_ack(0, 200, "t2a");
    @(negedge clk);
    check("t2_gap", 32'(grant), 0);
    req0 = 1'b1;
    @(negedge clk);
    check("t2_second", 32'(grant), 'b10);
    check("t2_second_addr", 32'(cmd_address), 'h22);
    wait_ack(1, 200, "t2b");
    repeat (2) @(negedge clk);
    check("t2_third", 32'(grant), 'b01);
    wait_ack(0, 200, "t2c");

    // req1 arrives mid-transfer with churning inputs
    repeat (3) @(negedge clk);
    ctl_dly = 1; ctl_hold = 12;
    req0 = 1'b1; r0_address = 7'h5A; r0_data_0 = 8'hA5; r0_data_1 = 8'h3C;
    n = 0;
    while (i2c_busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("t3_busy_seen", 32'(i2c_busy), 1);
    repeat (2) @(negedge clk);
    req1 = 1'b1;
    n = 0;
    while (ack0 !== 1'b1 && n < 100) begin
      check("t3_hold_addr", 32'(cmd_address), 'h5A);
      r1_address = 7'($urandom); r1_data_0 = 8'($urandom); r1_data_1 = 8'($urandom);
      @(negedge clk); n++;
    end
    check("t3_ack0", 32'(ack0), 1);
    check("t3_latched", 32'({cmd_address, data_0, data_1}), 32'({7'h5A, 8'hA5, 8'h3C}));
    req0 = 1'b0;
    sv_addr = r1_address;
    @(negedge clk);
    check("t3_idle_gap", 32'(grant), 0);
    @(negedge clk);
    check("t3_req1_grant", 32'(grant), 'b10);
    check("t3_req1_start", 32'(i2c_start), 1);
    check("t3_req1_addr", 32'(cmd_address), 32'(sv_addr));
    wait_ack(1, 200, "t3");

    // reset while waiting for busy to fall
    repeat (3) @(negedge clk);
    ctl_manual = 1'b1; man_busy = 1'b0;
    req0 = 1'b1; r0_address = 7'h07; r0_data_0 = 8'h70; r0_data_1 = 8'h77;
    @(negedge clk);
    man_busy = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_in_transfer", 32'(grant), 'b01);
    #2 rst = 1'b0; #1;
    check("t4_rst_grant", 32'(grant), 0);
    check("t4_rst_start", 32'(i2c_start), 0);
    req0 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1; man_busy = 1'b0;
    cnt = 0;
    repeat (5) begin @(negedge clk); if (ack0 || ack1) cnt++; end
    check("t4_no_ack", cnt, 0);
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    check("t4_tie_after_rst", 32'(grant), 'b01);
    req1 = 1'b0;
    man_busy = 1'b1;
    repeat (3) @(negedge clk);
    man_busy = 1'b0;
    wait_ack(0, 50, "t4");

    // busy stuck low after start
    repeat (3) @(negedge clk);
    req0 = 1'b1;
    @(negedge clk);
    check("t5_start", 32'(i2c_start), 1);
`ifdef I2C_ARB_TIMEOUT_EN
    repeat (TMO - 1) @(negedge clk);
    check("t5_not_early", 32'(ack0), 0);
    @(negedge clk);
    check("t5_ack0", 32'(ack0), 1);
    check("t5_err0", 32'(err0), 1);
    req0 = 1'b0; man_busy = 1'b1; req1 = 1'b1;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (grant != 2'b00) cnt++; end
    check("t5_blocked_by_busy", cnt, 0);
    man_busy = 1'b0;
    @(negedge clk);
    check("t5_grant_after_busy", 32'(grant), 'b10);
    wait_ack(1, 300, "t5");
    check("t5_err1", 32'(err1), 1);
`else
    cnt = 0;
    repeat (10000) begin @(negedge clk); if (ack0 || err0) cnt++; end
    check("t5_no_ack", cnt, 0);
    check("t5_still_owned", 32'(grant), 'b01);
    req0 = 1'b0;
    do_reset("t5_rst");
`endif

    // randomized traffic
    repeat (3) @(negedge clk);
    ctl_manual = 1'b0; ctl_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (req0 && ack0) req0 = 1'b0;
      else if (!req0 && !grant[0] && !ack0 && $urandom_range(0, 5) == 0) begin
        req0 = 1'b1; r0_address = 7'($urandom); r0_data_0 = 8'($urandom); r0_data_1 = 8'($urandom);
      end else if (req0 && !grant[0] && $urandom_range(0, 40) == 0) req0 = 1'b0;
      else if (req0 && grant[0] && $urandom_range(0, 30) == 0) req0 = 1'b0;
      else if (grant[0] && $urandom_range(0, 9) == 0) r0_data_0 = 8'($urandom);
      if (req1 && ack1) req1 = 1'b0;
      else if (!req1 && !grant[1] && !ack1 && $urandom_range(0, 5) == 0) begin
        req1 = 1'b1; r1_address = 7'($urandom); r1_data_0 = 8'($urandom); r1_data_1 = 8'($urandom);
      end else if (req1 && !grant[1] && $urandom_range(0, 40) == 0) req1 = 1'b0;
      else if (req1 && grant[1] && $urandom_range(0, 30) == 0) req1 = 1'b0;
      else if (grant[1] && $urandom_range(0, 9) == 0) r1_address = 7'($urandom);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (100) @(negedge clk);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
